elevator_ctrl: RTL and testbench
================================

# elevator_ctrl

Parametrised multi-floor elevator controller: the next-generation successor to the single-car up/down/door FSM. It latches per-floor call requests, schedules service with a SCAN (collective) policy, sequences travel and door timing with internal counters, and drives the hoist and door motors. It sits between the floor call-button decoder and the motor drivers. Door re-open is triggered by an obstruction or by a call at the current floor.

## Interface
- N_FLOORS, 8: number of floors. Must be at least 2.
- FLOOR_W, 3: floor index width. Must equal ceil(log2(N_FLOORS)).
- TRAVEL_CYCLES, 4: clock cycles to travel one floor. Must be at least 1.
- DOOR_CYCLES, 3: clock cycles for a door open or close movement. Must be at least 1.
- DWELL_CYCLES, 8: clock cycles the door stays fully open. Must be at least 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- call_req  in  N_FLOORS  per-floor call; level-sampled each edge, one-hot or multi-hot.
- door_obstruct  in  1  door obstruction sensor, active high.
- motor_up  out  1  hoist drive up.
- motor_down  out  1  hoist drive down.
- door_motor_open  out  1  door drive open.
- door_motor_close  out  1  door drive close.
- current_floor  out  FLOOR_W  floor the car is at, or last passed.
- dir_up  out  1  sweep direction: 1 = up, 0 = down.
- pending  out  N_FLOORS  latched, unserved requests.

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN, OPENING, DWELL, CLOSING.
- Outputs are Moore-decoded from the state register:
  - motor_up only in MOVE_UP.
  - motor_down only in MOVE_DOWN.
  - door_motor_open only in OPENING.
  - door_motor_close only in CLOSING.
  - At most one output is ever high.
- Effective requests: eff = pending | call_req. All decisions use eff.
- "above" means any eff bit at an index greater than current_floor; "below" means any at a smaller index.
- pending[i] is set when call_req[i] is high. Exception: i == current_floor while in OPENING, DWELL or CLOSING; that call is absorbed and not latched.
- pending[current_floor] is cleared on the transition into OPENING. Clear wins over set in that cycle.
- IDLE, in priority order:
  - eff[current_floor] -> OPENING.
  - else above and (dir_up or not below) -> MOVE_UP, dir_up=1.
  - else below -> MOVE_DOWN, dir_up=0.
  - else stay.
- MOVE_UP / MOVE_DOWN:
  - A counter runs 0..TRAVEL_CYCLES-1.
  - At terminal count, current_floor is incremented/decremented and the arrival decision is made on the new floor.
  - Arrival: eff[new] -> OPENING; else continue the same direction if requests remain beyond the new floor (counter restarts); else IDLE.
  - Floor is never driven past 0 or N_FLOORS-1. At a limit, the FSM goes to IDLE.
- OPENING: runs DOOR_CYCLES cycles, then DWELL.
- DWELL:
  - Runs DWELL_CYCLES cycles, then CLOSING.
  - door_obstruct or call_req[current_floor] resets the counter to 0.
- CLOSING:
  - Runs DOOR_CYCLES cycles, then IDLE.
  - door_obstruct or call_req[current_floor] -> OPENING with the counter reset. dir_up is unchanged.
- After CLOSING, IDLE continues the sweep in dir_up if requests remain that way; otherwise it reverses.

## Timing
- Reset (reset=0 at an edge):
  - state=IDLE, current_floor=0, dir_up=1, pending=0, all counters 0.
  - All motor outputs are 0 from the following cycle.
- Reset mid-operation abandons motion and requests immediately; there is no position memory.
- Request-to-response latency: call_req high at edge t while IDLE gives the motor or door output high from cycle t+1.
- Per-floor travel: motor high exactly TRAVEL_CYCLES cycles. Motor stays continuously high across non-stop floors.
- current_floor updates on the same edge that ends the last travel cycle.
- Door sequence with no disturbance: DOOR_CYCLES open, DWELL_CYCLES idle-open, DOOR_CYCLES close, then IDLE.
- A call at a floor being reached, high on the arrival edge, stops the car there.
- A call at a floor already passed waits for the reverse sweep.
- A simultaneous obstruction and dwell expiry keeps the door in DWELL.

## Test plan
- Reset, then call_req=0x01 for 1 cycle at floor 0:
  - door_motor_open high 3 cycles, then all outputs low 8 cycles, then door_motor_close high 3 cycles, then IDLE.
  - pending stays 0.
- From floor 0 idle, pulse call_req[3]:
  - motor_up high 12 consecutive cycles.
  - current_floor steps 1, 2, 3 at cycles 4, 8, 12.
  - Then OPENING and pending[3] cleared.
- SCAN ordering: car at floor 2 moving up toward 6; pulse floor 4 and floor 1 together:
  - Stops at 4, then at 6.
  - Reverses with dir_up=0 and serves floor 1 last.
  - motor_down is never high before floor 6 is served.
- Door handling:
  - door_obstruct during CLOSING cycle 2 re-enters OPENING.
  - door_obstruct held 20 cycles during DWELL keeps the door open 20+8 cycles.
  - call_req[current_floor] during DWELL is never latched.
- Reset mid-travel: assert reset=0 during MOVE_UP between floors 4 and 5:
  - Next cycle all outputs 0, current_floor=0, pending=0.
  - Any pending value is discarded.
- Boundaries:
  - call_req=all-ones at floor 0 opens floor 0 first, then visits 1..7 upward, each with a full door cycle.
  - motor_up is never high at floor 7.

Source files
------------

// File: rtl/elevator_ctrl.sv
// Multi-floor elevator controller: latches floor calls, serves them with a SCAN sweep,
// and sequences hoist travel and door open/dwell/close timing with one shared counter.
module elevator_ctrl #(
    parameter int unsigned N_FLOORS      = 8,
    parameter int unsigned FLOOR_W       = 3,
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 3,
    parameter int unsigned DWELL_CYCLES  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] call_req,
    input  logic                door_obstruct,
    output logic                motor_up,
    output logic                motor_down,
    output logic                door_motor_open,
    output logic                door_motor_close,
    output logic [FLOOR_W-1:0]  current_floor,
    output logic                dir_up,
    output logic [N_FLOORS-1:0] pending
);

    localparam int unsigned CNT_MAX_TD = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int unsigned CNT_MAX    = (CNT_MAX_TD > DWELL_CYCLES) ? CNT_MAX_TD : DWELL_CYCLES;
    localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(N_FLOORS - 1);
    localparam logic [CNT_W-1:0]   TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE_UP,
        S_MOVE_DOWN,
        S_OPENING,
        S_DWELL,
        S_CLOSING
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [FLOOR_W-1:0]  r_floor;
    logic                r_dir_up;
    logic [N_FLOORS-1:0] r_pending;
    logic                r_motor_up;
    logic                r_motor_down;
    logic                r_door_open;
    logic                r_door_close;

    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [FLOOR_W-1:0]  w_floor_nxt;
    logic                w_dir_nxt;
    logic [N_FLOORS-1:0] w_pending_nxt;
    logic [N_FLOORS-1:0] w_set;
    logic [N_FLOORS-1:0] w_eff;
    logic                w_above;
    logic                w_below;
    logic                w_door_busy;
    logic                w_hold;

    function automatic logic any_above(input logic [N_FLOORS-1:0] req, input logic [FLOOR_W-1:0] fl);
        logic r;
        r = 1'b0;
        for (int i = 0; i < int'(N_FLOORS); i++) begin
            if (i > int'(fl)) r = r | req[i];
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [N_FLOORS-1:0] req, input logic [FLOOR_W-1:0] fl);
        logic r;
        r = 1'b0;
        for (int i = 0; i < int'(N_FLOORS); i++) begin
            if (i < int'(fl)) r = r | req[i];
        end
        return r;
    endfunction

    assign w_eff       = r_pending | call_req;
    assign w_above     = any_above(w_eff, r_floor);
    assign w_below     = any_below(w_eff, r_floor);
    assign w_door_busy = (r_state == S_OPENING) || (r_state == S_DWELL) || (r_state == S_CLOSING);
    assign w_hold      = door_obstruct | call_req[r_floor];

    // State register plus registered Moore outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_floor      <= '0;
            r_dir_up     <= 1'b1;
            r_pending    <= '0;
            r_motor_up   <= 1'b0;
            r_motor_down <= 1'b0;
            r_door_open  <= 1'b0;
            r_door_close <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_floor      <= w_floor_nxt;
            r_dir_up     <= w_dir_nxt;
            r_pending    <= w_pending_nxt;
            r_motor_up   <= (w_state_nxt == S_MOVE_UP);
            r_motor_down <= (w_state_nxt == S_MOVE_DOWN);
            r_door_open  <= (w_state_nxt == S_OPENING);
            r_door_close <= (w_state_nxt == S_CLOSING);
        end
    end

    // Next-state, counter, floor, direction and request bookkeeping.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_floor_nxt   = r_floor;
        w_dir_nxt     = r_dir_up;
        w_set         = call_req;
        w_pending_nxt = r_pending;

        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_eff[r_floor]) begin
                    w_state_nxt = S_OPENING;
                end else if (w_above && (r_dir_up || !w_below)) begin
                    w_state_nxt = S_MOVE_UP;
                    w_dir_nxt   = 1'b1;
                end else if (w_below) begin
                    w_state_nxt = S_MOVE_DOWN;
                    w_dir_nxt   = 1'b0;
                end
            end
            S_MOVE_UP: begin
                if (r_floor == TOP_FLOOR) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TRAVEL_LAST) begin
                    w_cnt_nxt   = '0;
                    w_floor_nxt = r_floor + FLOOR_W'(1);
                    if (w_eff[w_floor_nxt])                    w_state_nxt = S_OPENING;
                    else if (!any_above(w_eff, w_floor_nxt))   w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_MOVE_DOWN: begin
                if (r_floor == '0) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TRAVEL_LAST) begin
                    w_cnt_nxt   = '0;
                    w_floor_nxt = r_floor - FLOOR_W'(1);
                    if (w_eff[w_floor_nxt])                    w_state_nxt = S_OPENING;
                    else if (!any_below(w_eff, w_floor_nxt))   w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_OPENING: begin
                if (r_cnt == DOOR_LAST) begin
                    w_state_nxt = S_DWELL;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DWELL: begin
                // A disturbance wins over expiry, so the door stays open.
                if (w_hold) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == DWELL_LAST) begin
                    w_state_nxt = S_CLOSING;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_CLOSING: begin
                if (w_hold) begin
                    w_state_nxt = S_OPENING;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DOOR_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Calls at the floor whose door is active are absorbed; opening clears that floor.
        if (w_door_busy) w_set[r_floor] = 1'b0;
        w_pending_nxt = r_pending | w_set;
        if ((w_state_nxt == S_OPENING) && (r_state != S_OPENING)) w_pending_nxt[w_floor_nxt] = 1'b0;
    end

    assign motor_up         = r_motor_up;
    assign motor_down       = r_motor_down;
    assign door_motor_open  = r_door_open;
    assign door_motor_close = r_door_close;
    assign current_floor    = r_floor;
    assign dir_up           = r_dir_up;
    assign pending          = r_pending;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboard bench for elevator_ctrl: stimulus queues expected output segments
// (output pattern, length, start floor, direction); a negedge monitor cuts and checks them.
module tb_elevator_ctrl;

    localparam logic [3:0] UP = 4'b1000;
    localparam logic [3:0] DN = 4'b0100;
    localparam logic [3:0] OP = 4'b0010;
    localparam logic [3:0] CL = 4'b0001;
    localparam logic [3:0] ZZ = 4'b0000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] call_req = 8'h00;
    logic       door_obstruct = 1'b0;
    logic       motor_up, motor_down, door_motor_open, door_motor_close;
    logic [2:0] current_floor;
    logic       dir_up;
    logic [7:0] pending;

    typedef struct {
        logic [3:0] outs;
        int         len;
        int         fl;
        int         dir;
    } seg_t;

    seg_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   seg_idx  = 0;
    logic mon_en   = 1'b0;

    elevator_ctrl #(
        .N_FLOORS(8), .FLOOR_W(3), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3), .DWELL_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset), .call_req(call_req), .door_obstruct(door_obstruct),
        .motor_up(motor_up), .motor_down(motor_down),
        .door_motor_open(door_motor_open), .door_motor_close(door_motor_close),
        .current_floor(current_floor), .dir_up(dir_up), .pending(pending)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Segment monitor: a segment ends when the output pattern changes.
    logic [3:0] cur_v;
    int         cur_len;
    int         cur_fl;
    int         cur_dir;
    logic       started = 1'b0;

    always @(negedge clk) begin
        logic [3:0] v;
        seg_t       e;
        if (mon_en) begin
            v = {motor_up, motor_down, door_motor_open, door_motor_close};
            if (!started) begin
                cur_v = v; cur_len = 1; cur_fl = int'(current_floor); cur_dir = int'(dir_up);
                started = 1'b1;
            end else if (v == cur_v) begin
                cur_len++;
            end else begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL seg%0d unexpected: got outs=%b len=%0d floor=%0d, expected no segment",
                             seg_idx, cur_v, cur_len, cur_fl);
                end else begin
                    e = exp_q.pop_front();
                    if (cur_v !== e.outs || (e.len > 0 && cur_len != e.len) ||
                        (e.fl >= 0 && cur_fl != e.fl) || (e.dir >= 0 && cur_dir != e.dir)) begin
                        n_errors++;
                        $display("FAIL seg%0d: got outs=%b len=%0d floor=%0d dir=%0d, expected outs=%b len=%0d floor=%0d dir=%0d",
                                 seg_idx, cur_v, cur_len, cur_fl, cur_dir, e.outs, e.len, e.fl, e.dir);
                    end
                end
                seg_idx++;
                cur_v = v; cur_len = 1; cur_fl = int'(current_floor); cur_dir = int'(dir_up);
            end
        end
    end

    task automatic push_seg(input logic [3:0] o, input int len, input int fl, input int dir);
        seg_t s;
        s.outs = o; s.len = len; s.fl = fl; s.dir = dir;
        exp_q.push_back(s);
    endtask

    task automatic push_door(input int fl, input int dir);
        push_seg(OP, 3, fl, dir);
        push_seg(ZZ, 8, fl, dir);
        push_seg(CL, 3, fl, dir);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Called just after a posedge; returns just after the edge that sampled the call.
    task automatic pulse_call(input logic [7:0] v);
        call_req = v;
        @(posedge clk); #1;
        call_req = 8'h00;
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (exp_q.size() > 1 && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        chk({nm, "_drain_left"}, 32'(exp_q.size() > 1 ? exp_q.size() : 1), 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_floor", 32'(current_floor), 32'd0);
        chk("rst_dir", 32'(dir_up), 32'd1);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_outs", 32'({motor_up, motor_down, door_motor_open, door_motor_close}), 32'd0);
        reset = 1'b1;
        push_seg(ZZ, 0, -1, -1);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Call at the current floor: door cycle only, nothing latched
        push_door(0, 1);
        push_seg(ZZ, 0, -1, -1);
        pulse_call(8'h01);
        chk("t1_pending", 32'(pending), 32'd0);
        drain("t1");
        chk("t1_pending_end", 32'(pending), 32'd0);

        // Floor 0 to floor 3
        push_seg(UP, 12, 0, 1);
        push_door(3, 1);
        push_seg(ZZ, 0, -1, -1);
        pulse_call(8'h08);
        chk("t2_pending_set", 32'(pending), 32'h08);
        repeat (4) @(posedge clk); #1;
        chk("t2_floor_c4", 32'(current_floor), 32'd1);
        repeat (4) @(posedge clk); #1;
        chk("t2_floor_c8", 32'(current_floor), 32'd2);
        repeat (4) @(posedge clk); #1;
        chk("t2_floor_c12", 32'(current_floor), 32'd3);
        chk("t2_opening", 32'(door_motor_open), 32'd1);
        chk("t2_pending_clr", 32'(pending), 32'd0);
        drain("t2");

        // SCAN ordering: heading to 6, floors 4 and 1 called while passing floor 2
        do_reset();
        @(posedge clk); #1;
        chk("t3_rst_floor", 32'(current_floor), 32'd0);
        push_seg(UP, 16, 0, 1);
        push_door(4, 1);
        push_seg(ZZ, 1, -1, -1);
        push_seg(UP, 8, 4, 1);
        push_door(6, 1);
        push_seg(ZZ, 1, -1, -1);
        push_seg(DN, 20, 6, 0);
        push_door(1, 0);
        push_seg(ZZ, 0, -1, -1);
        pulse_call(8'h40);
        repeat (9) @(posedge clk); #1;
        pulse_call(8'h12);
        chk("t3_pending", 32'(pending), 32'h52);
        drain("t3");
        chk("t3_dir_end", 32'(dir_up), 32'd0);
        chk("t3_pending_end", 32'(pending), 32'd0);

        // Obstruction in closing cycle 2 re-opens the door
        push_seg(OP, 3, 1, 0);
        push_seg(ZZ, 8, 1, 0);
        push_seg(CL, 2, 1, 0);
        push_door(1, 0);
        push_seg(ZZ, 0, -1, -1);
        pulse_call(8'h02);
        repeat (12) @(posedge clk); #1;
        door_obstruct = 1'b1;
        @(posedge clk); #1;
        door_obstruct = 1'b0;
        drain("t4a");

        // Obstruction held 20 cycles from the first dwell cycle
        push_seg(OP, 3, 1, 0);
        push_seg(ZZ, 28, 1, 0);
        push_seg(CL, 3, 1, 0);
        push_seg(ZZ, 0, -1, -1);
        pulse_call(8'h02);
        repeat (3) @(posedge clk); #1;
        door_obstruct = 1'b1;
        repeat (20) @(posedge clk); #1;
        door_obstruct = 1'b0;
        drain("t4b");

        // Same-floor call during dwell restarts dwell and is not latched
        push_seg(OP, 3, 1, 0);
        push_seg(ZZ, 9, 1, 0);
        push_seg(CL, 3, 1, 0);
        push_seg(ZZ, 0, -1, -1);
        pulse_call(8'h02);
        repeat (3) @(posedge clk); #1;
        pulse_call(8'h02);
        chk("t4c_pending", 32'(pending), 32'd0);
        drain("t4c");

        // Reset between floors 4 and 5 discards motion and requests
        push_seg(UP, 15, 1, 1);
        push_seg(ZZ, 0, -1, -1);
        pulse_call(8'h80);
        repeat (5) @(posedge clk); #1;
        pulse_call(8'h04);
        repeat (8) @(posedge clk); #1;
        chk("t5_pending_pre", 32'(pending), 32'h84);
        chk("t5_floor_pre", 32'(current_floor), 32'd4);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("t5_outs", 32'({motor_up, motor_down, door_motor_open, door_motor_close}), 32'd0);
        chk("t5_floor", 32'(current_floor), 32'd0);
        chk("t5_pending", 32'(pending), 32'd0);
        chk("t5_dir", 32'(dir_up), 32'd1);
        drain("t5");

        // All floors called at floor 0: serve 0, then 1..7 upward
        push_door(0, 1);
        for (int f = 1; f < 8; f++) begin
            push_seg(ZZ, 1, -1, -1);
            push_seg(UP, 4, f - 1, 1);
            push_door(f, 1);
        end
        push_seg(ZZ, 0, -1, -1);
        pulse_call(8'hFF);
        chk("t6_pending", 32'(pending), 32'hFE);
        drain("t6");
        chk("t6_floor_end", 32'(current_floor), 32'd7);
        chk("t6_pending_end", 32'(pending), 32'd0);
        chk("t6_motor_up_top", 32'(motor_up), 32'd0);

        chk("final_queue", 32'(exp_q.size()), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
